i2s_tx: RTL



---
 rtl/i2s_pkg.sv | 21 ++
 rtl/i2s_bclk_gen.sv | 49 ++++
 rtl/i2s_tx.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmitter: default geometry, frame
// length, FSM state encoding and the word-select helper.
package i2s_pkg;

    localparam int DEF_DATA_W   = 24;
    localparam int DEF_SLOT_W   = 32;
    localparam int DEF_BCLK_DIV = 4;
    localparam int FRAME_BITS   = 2 * DEF_SLOT_W;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Word select for bit k of a frame: it switches one BCLK ahead of the
    // channel MSB, so it already reflects bit k+1.
    function automatic logic ws_for(input int k, input int slot_w);
        return ((k + 1) % (2 * slot_w)) >= slot_w;
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock generator: divides clk by BCLK_DIV while running, drives a
// registered BCLK and flags the cycle that produces each BCLK falling edge.
module i2s_bclk_gen
    import i2s_pkg::*;
#(
    parameter int BCLK_DIV = DEF_BCLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_run,
    output logic o_bclk,
    output logic o_fall
);

    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);

    logic [DIV_W-1:0] r_div_cnt;
    logic [DIV_W-1:0] w_div_nxt;
    logic             r_bclk;

    // Next divider value: parked at 0 when not running, else count and wrap.
    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_div_nxt = '0;
        if (i_run) begin
            w_div_nxt = (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
        end
    end

    // Divider and BCLK registers; BCLK tracks the upper half of the count.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else begin
            r_div_cnt <= w_div_nxt;
            r_bclk    <= i_run && (w_div_nxt >= DIV_HALF);
        end
    end

    assign o_fall = i_run && (r_div_cnt == DIV_LAST);
    assign o_bclk = r_bclk;

endmodule

// File: rtl/i2s_tx.sv
// I2S (Philips) master transmitter: one-entry valid/ready holding buffer,
// IDLE/RUN FSM that only stops on frame boundaries, and an MSB-first shifter.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int SLOT_W   = DEF_SLOT_W,
    parameter int BCLK_DIV = DEF_BCLK_DIV
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    output logic              i2s_bclk,
    output logic              i2s_ws,
    output logic              i2s_sd,
    output logic              busy,
    output logic              underrun
);

    localparam int FRAME_N = 2 * SLOT_W;
    localparam int CNT_W   = $clog2(FRAME_N);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_N - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [CNT_W-1:0]   w_bit_nxt;
    logic [FRAME_N-1:0] r_shift;
    logic [FRAME_N-1:0] w_frame;
    logic [DATA_W-1:0]  r_hold_l;
    logic [DATA_W-1:0]  r_hold_r;
    logic               r_hold_full;
    logic               r_ws;
    logic               r_sd;
    logic               r_underrun;
    logic               w_fall;
    logic               w_start;
    logic               w_advance;
    logic               w_stop;
    logic               w_accept;
    logic               w_ws_nxt;

    i2s_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_run  (r_state == RUN),
        .o_bclk (i2s_bclk),
        .o_fall (w_fall)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the per-cycle frame start / bit advance / stop strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_advance   = 1'b0;
        w_stop      = 1'b0;
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_state_nxt = RUN;
                    w_start     = 1'b1;
                end
            end
            RUN: begin
                if (w_fall) begin
                    if (r_bit_cnt != BIT_LAST) begin
                        w_advance = 1'b1;
                    end else if (en) begin
                        w_start = 1'b1;
                    end else begin
                        w_stop      = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Frame image from the holding buffer (zeros if empty) and next-bit WS.
    always_comb begin
        w_frame = '0;
        if (r_hold_full) begin
            w_frame[FRAME_N-1 -: DATA_W] = r_hold_l;
            w_frame[SLOT_W-1 -: DATA_W]  = r_hold_r;
        end
        w_bit_nxt = r_bit_cnt + 1'b1;
        w_ws_nxt  = ws_for(int'(w_bit_nxt), SLOT_W);
    end

    // Bit counter, shifter and the registered serial outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_ws       <= 1'b0;
            r_sd       <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (w_start) begin
                r_bit_cnt  <= '0;
                r_shift    <= w_frame << 1;
                r_sd       <= w_frame[FRAME_N-1];
                r_ws       <= ws_for(0, SLOT_W);
                r_underrun <= !r_hold_full;
            end else if (w_advance) begin
                r_bit_cnt <= w_bit_nxt;
                r_shift   <= r_shift << 1;
                r_sd      <= r_shift[FRAME_N-1];
                r_ws      <= w_ws_nxt;
            end else if (w_stop) begin
                r_bit_cnt <= '0;
                r_shift   <= '0;
                r_sd      <= 1'b0;
                r_ws      <= 1'b0;
            end
        end
    end

    assign w_accept = s_valid && !r_hold_full;

    // Holding-buffer flag: set on acceptance, cleared when a frame consumes it.
    // Accept and consume are mutually exclusive because accept needs it empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_full <= 1'b0;
        end else if (w_accept) begin
            r_hold_full <= 1'b1;
        end else if (w_start) begin
            r_hold_full <= 1'b0;
        end
    end

    // Holding-buffer payload, captured only on acceptance.
    // NOTE: data storage has no reset; it is only read while r_hold_full is
    // set, so the flag alone carries the reset meaning.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_hold_l <= s_left;
            r_hold_r <= s_right;
        end
    end

    assign s_ready  = !r_hold_full;
    assign busy     = (r_state == RUN);
    assign i2s_ws   = r_ws;
    assign i2s_sd   = r_sd;
    assign underrun = r_underrun;

endmodule
